// File: rtl/aes_key_schedule_seq_pkg.sv
// Shared types and helpers for the sequential AES key-schedule engine.
// The optional reverse-order read port is enabled by KEY_SCHED_REVERSE_EN in the top.
package aes_key_pkg;
  localparam int WORD_W = 32;

  localparam logic [1:0] ALG_128 = 2'b00;
  localparam logic [1:0] ALG_192 = 2'b01;
  localparam logic [1:0] ALG_256 = 2'b10;
  localparam logic [1:0] ALG_ILL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0] nk;
    logic [3:0] nr;
  } alg_cfg_t;

  function automatic alg_cfg_t alg_cfg(input logic [1:0] alg);
    alg_cfg_t c;
    case (alg)
      ALG_192: begin c.nk = 4'd6; c.nr = 4'd12; end
      ALG_256: begin c.nk = 4'd8; c.nr = 4'd14; end
      default: begin c.nk = 4'd4; c.nr = 4'd10; end
    endcase
    return c;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/aes_key_schedule_seq_sbox.sv
// Combinational AES forward S-box, one byte lane.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  // Entry for input x sits at bits [8*(255-x) +: 8], so ~a selects the slot directly.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign s = SBOX[{~a, 3'b000} +: 8];
endmodule

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128/192/256 key expander: one word per clock into a round-key store.
// Define KEY_SCHED_REVERSE_EN to add rd_rev (read round keys in decryption order).
module aes_key_schedule_seq
  import aes_key_pkg::*;
#(
  parameter int MAX_NR = 14,
  parameter int RD_REG = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] key,
  input  logic [1:0]   algorithm,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  output logic         cfg_err,
  output logic [3:0]   nr,
  input  logic [3:0]   rd_idx,
`ifdef KEY_SCHED_REVERSE_EN
  input  logic         rd_rev,
`endif
  output logic [127:0] rd_key,
  output logic         rd_err
);
  localparam int DEPTH = 4 * (MAX_NR + 1);
  localparam int IW    = $clog2(DEPTH);

  logic [WORD_W-1:0] w_mem [DEPTH];

  state_e          state_q, state_d;
  alg_cfg_t        cfg_in;
  logic [3:0]      nk_q, nr_q;
  logic [IW-1:0]   wi_q;
  logic [2:0]      ph_q;
  logic [7:0]      rcon_q;
  logic            accept, bad_cfg, last_word, expanding;

  assign cfg_in    = alg_cfg(algorithm);
  assign expanding = (state_q == ST_EXPAND);
  assign last_word = (wi_q == IW'({nr_q, 2'b00} + 6'd3));
  assign busy      = expanding;
  assign nr        = nr_q;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    bad_cfg = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (algorithm == ALG_ILL) bad_cfg = 1'b1;
          else begin
            accept  = 1'b1;
            state_d = ST_EXPAND;
          end
        end
      end
      ST_EXPAND: if (last_word) state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Expansion datapath: w[i] = w[i-Nk] ^ f(w[i-1])
  logic [WORD_W-1:0]  prev_w, far_w, rot_w, temp_w, new_w;
  logic [3:0][7:0]    sub_in, sub_out;

  assign prev_w = w_mem[wi_q - IW'(1)];
  assign far_w  = w_mem[wi_q - IW'(nk_q)];
  assign rot_w  = {prev_w[23:0], prev_w[31:24]};
  assign sub_in = (ph_q == 3'd0) ? rot_w : prev_w;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.a(sub_in[g]), .s(sub_out[g]));
  end

  always_comb begin
    temp_w = prev_w;
    if (ph_q == 3'd0)                       temp_w = sub_out ^ {rcon_q, 24'h0};
    else if (nk_q == 4'd8 && ph_q == 3'd4)  temp_w = sub_out;
    new_w = far_w ^ temp_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      nk_q       <= '0;
      nr_q       <= '0;
      wi_q       <= '0;
      ph_q       <= '0;
      rcon_q     <= '0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= expanding && last_word;
      cfg_err <= bad_cfg;
      if (accept) begin
        nk_q       <= cfg_in.nk;
        nr_q       <= cfg_in.nr;
        wi_q       <= IW'(cfg_in.nk);
        ph_q       <= '0;
        rcon_q     <= 8'h01;
        keys_valid <= 1'b0;
      end else if (expanding) begin
        wi_q <= wi_q + IW'(1);
        ph_q <= ({1'b0, ph_q} == nk_q - 4'd1) ? 3'd0 : ph_q + 3'd1;
        if (ph_q == 3'd0) rcon_q <= xtime(rcon_q);
        if (last_word) keys_valid <= 1'b1;
      end
    end
  end

  // Cipher-key words land in one cycle; expanded words follow one per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) w_mem[k] <= '0;
    end else if (accept) begin
      for (int k = 0; k < 8; k++)
        if (k < int'(cfg_in.nk)) w_mem[k] <= key[255-32*k -: 32];
    end else if (expanding) begin
      w_mem[wi_q] <= new_w;
    end
  end

  // Read port
  logic [3:0]    eff_idx;
  logic [IW-1:0] base;
  logic          rd_err_c;
  logic [127:0]  rd_key_c;

  always_comb begin
`ifdef KEY_SCHED_REVERSE_EN
    eff_idx = rd_rev ? (nr_q - rd_idx) : rd_idx;
`else
    eff_idx = rd_idx;
`endif
    rd_err_c = !keys_valid || (rd_idx > nr_q);
    base     = IW'({eff_idx, 2'b00});
    rd_key_c = '0;
    if (!rd_err_c)
      rd_key_c = {w_mem[base], w_mem[base + IW'(1)], w_mem[base + IW'(2)], w_mem[base + IW'(3)]};
  end

  if (RD_REG != 0) begin : g_rd_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_key <= '0;
        rd_err <= 1'b0;
      end else begin
        rd_key <= rd_key_c;
        rd_err <= rd_err_c;
      end
    end
  end else begin : g_rd_comb
    assign rd_key = rd_key_c;
    assign rd_err = rd_err_c;
  end
endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Scoreboard bench for aes_key_schedule_seq against a FIPS-197 style reference model.
module tb_aes_key_schedule_seq;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] key = '0;
  logic [1:0]   algorithm = 2'b00;
  logic         start = 1'b0;
  logic         busy, done, keys_valid, cfg_err, rd_err;
  logic [3:0]   nr;
  logic [3:0]   rd_idx = '0;
  logic         rd_rev = 1'b0;
  logic [127:0] rd_key;

  aes_key_schedule_seq dut (
    .clk(clk), .rst_n(rst_n), .key(key), .algorithm(algorithm), .start(start),
    .busy(busy), .done(done), .keys_valid(keys_valid), .cfg_err(cfg_err), .nr(nr),
    .rd_idx(rd_idx),
`ifdef KEY_SCHED_REVERSE_EN
    .rd_rev(rd_rev),
`endif
    .rd_key(rd_key), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic err; logic [127:0] key; string tag; } rd_exp_t;
  rd_exp_t rd_q[$];
  int      done_q[$];
  logic    rd_req = 1'b0, rd_pend = 1'b0;
  always @(posedge clk) rd_pend <= rd_req;

  // Reference model state
  logic [7:0]  sbox [256];
  logic [31:0] m_w [60];
  logic        m_valid = 1'b0;
  int          m_nr = 0;

  function automatic void check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in, b = b_in, p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
  endfunction

  function automatic void model_expand(input logic [255:0] k, input int nk, input int nrv);
    logic [7:0]  rc = 8'h01;
    logic [31:0] t;
    for (int i = 0; i < nk; i++) m_w[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4*(nrv+1); i++) begin
      t = m_w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      m_w[i] = m_w[i-nk] ^ t;
    end
  endfunction

  function automatic rd_exp_t model_read(input int idx, input logic rev, input string tag);
    rd_exp_t e;
    int eff;
    eff   = rev ? m_nr - idx : idx;
    e.tag = tag;
    e.err = !m_valid || idx > m_nr;
    e.key = e.err ? 128'h0 : {m_w[4*eff], m_w[4*eff+1], m_w[4*eff+2], m_w[4*eff+3]};
    return e;
  endfunction

  function automatic rd_exp_t kat(input logic err, input logic [127:0] k, input string tag);
    rd_exp_t e;
    e.err = err; e.key = k; e.tag = tag;
    return e;
  endfunction

  // Monitor: pops expectations whenever the DUT presents a done pulse or read result
  always @(negedge clk) begin
    rd_exp_t e;
    if (rst_n) begin
      if (done) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done at cycle %0d", cyc);
        end else check("done_cycle", cyc, done_q.pop_front());
      end
      if (rd_pend) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL read_without_expectation at cycle %0d", cyc);
        end else begin
          e = rd_q.pop_front();
          check({e.tag, "_err"}, rd_err, e.err);
          check({e.tag, "_key"}, rd_key, e.key);
        end
      end
    end
  end

  task automatic issue_read(input logic [3:0] idx, input logic rev, input rd_exp_t e);
    @(negedge clk);
    rd_idx = idx; rd_rev = rev; rd_req = 1'b1;
    rd_q.push_back(e);
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic start_job(input logic [1:0] alg, input logic [255:0] k, output int exp_cyc);
    int nk, nrv;
    @(negedge clk);
    key = k; algorithm = alg; start = 1'b1;
    exp_cyc = -1;
    if (alg != 2'b11) begin
      nk  = (alg == 2'b00) ? 4 : (alg == 2'b01) ? 6 : 8;
      nrv = nk + 6;
      model_expand(k, nk, nrv);
      m_nr = nrv; m_valid = 1'b0;
      exp_cyc = cyc + 1 + 4*(nrv+1) - nk;
      done_q.push_back(exp_cyc);
    end
    @(negedge clk);
    start = 1'b0;
    check("cfg_err_after_start", cfg_err, alg == 2'b11);
    check("busy_after_start", busy, alg != 2'b11);
  endtask

  task automatic wait_job(input int exp_cyc);
    int n = 0;
    while (cyc < exp_cyc && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (cyc < exp_cyc) begin
      checks++; errors++;
      $display("FAIL done_timeout waited=%0d cycles required_cycle=%0d", n, exp_cyc);
    end else begin
      m_valid = 1'b1;
      check("keys_valid_at_done", keys_valid, 1'b1);
      check("busy_at_done", busy, 1'b0);
      check("nr_at_done", nr, m_nr);
    end
  endtask

  task automatic random_reads(input int n);
    logic [3:0] idx;
    logic rev;
    for (int r = 0; r < n; r++) begin
      idx = 4'($urandom_range(0, 15));
`ifdef KEY_SCHED_REVERSE_EN
      rev = 1'($urandom_range(0, 1));
`else
      rev = 1'b0;
`endif
      issue_read(idx, rev, model_read(idx, rev, "rand_rd"));
    end
  endtask

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int ec;
    logic [255:0] k128, k192, k256;
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    // Reset values
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_keys_valid", keys_valid, 1'b0);
    check("rst_cfg_err", cfg_err, 1'b0);
    check("rst_rd_err", rd_err, 1'b0);
    check("rst_nr", nr, 4'd0);
    check("rst_rd_key", rd_key, 128'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    issue_read(4'd0, 1'b0, kat(1'b1, 128'h0, "rd_before_any_job"));

    // AES-128 known answer
    start_job(2'b00, k128, ec);
    issue_read(4'd3, 1'b0, kat(1'b1, 128'h0, "rd_during_expand"));
    wait_job(ec);
    issue_read(4'd0, 1'b0, kat(1'b0, 128'h2b7e151628aed2a6abf7158809cf4f3c, "aes128_rk0"));
    issue_read(4'd10, 1'b0, kat(1'b0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "aes128_rk10"));
    issue_read(4'd11, 1'b0, kat(1'b1, 128'h0, "aes128_rk11_oob"));
`ifdef KEY_SCHED_REVERSE_EN
    issue_read(4'd0, 1'b1, kat(1'b0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "aes128_rev0"));
    issue_read(4'd10, 1'b1, kat(1'b0, 128'h2b7e151628aed2a6abf7158809cf4f3c, "aes128_rev10"));
`endif

    // Illegal algorithm leaves the loaded schedule intact
    start_job(2'b11, rand_key(), ec);
    @(negedge clk);
    check("cfg_err_single_pulse", cfg_err, 1'b0);
    check("keys_valid_after_cfg_err", keys_valid, 1'b1);
    check("nr_after_cfg_err", nr, 4'd10);
    issue_read(4'd10, 1'b0, kat(1'b0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "rk10_after_cfg_err"));

    // AES-192 known answer
    start_job(2'b01, k192, ec);
    wait_job(ec);
    issue_read(4'd12, 1'b0, kat(1'b0, 128'he98ba06f448c773c8ecc720401002202, "aes192_rk12"));
    issue_read(4'd13, 1'b0, kat(1'b1, 128'h0, "aes192_rk13_oob"));

    // AES-256 known answer, with a stray start mid-expansion
    start_job(2'b10, k256, ec);
    repeat (10) @(negedge clk);
    start = 1'b1; algorithm = 2'b00; key = rand_key();
    @(negedge clk);
    start = 1'b0;
    check("busy_after_stray_start", busy, 1'b1);
    wait_job(ec);
    issue_read(4'd14, 1'b0, kat(1'b0, 128'hfe4890d1e6188d0b046df344706c631e, "aes256_rk14"));
    random_reads(4);

    // Randomized jobs for all three key sizes
    for (int j = 0; j < 6; j++) begin
      start_job(2'(j % 3), rand_key(), ec);
      wait_job(ec);
      random_reads(6);
    end

    // Reset in the middle of an AES-256 expansion
    start_job(2'b10, rand_key(), ec);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_keys_valid", keys_valid, 1'b0);
    check("midrst_cfg_err", cfg_err, 1'b0);
    check("midrst_rd_err", rd_err, 1'b0);
    check("midrst_nr", nr, 4'd0);
    check("midrst_rd_key", rd_key, 128'h0);
    done_q.delete();
    m_valid = 1'b0; m_nr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue_read(4'd0, 1'b0, kat(1'b1, 128'h0, "rd_after_midrst"));
    start_job(2'b00, k128, ec);
    wait_job(ec);
    issue_read(4'd10, 1'b0, kat(1'b0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "post_rst_rk10"));
    random_reads(4);

    repeat (3) @(negedge clk);
    if (done_q.size() != 0 || rd_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL pending_expectations done=%0d reads=%0d required=0", done_q.size(), rd_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
